// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC and walks each instruction
// through FETCH, EXEC and an optional post-load stall before the next fetch.
module fetch_sequencer #(
  parameter int              PC_W      = 10,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter int              LOAD_WAIT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [8:0]      imem_data,
  output logic [8:0]      ir,
  input  logic            branch_flag,
  input  logic            cond_branch,
  input  logic            branch_taken,
  input  logic            mem_to_reg,
  input  logic [PC_W-1:0] branch_target,
  output logic            exec_en,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic [15:0]     cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_LWAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(LOAD_WAIT);
  localparam bit         HAS_WAIT  = (LOAD_WAIT > 0);

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [8:0]        ir_reg, ir_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic [3:0]        wait_reg, wait_next;
  logic              is_halt;
  logic              active;

  // Halt is itype 0 with opcode 1111; the upper instruction bits are don't-care.
  assign is_halt = (ir_reg[4:0] == 5'b11110);
  assign active  = (state_reg == S_FETCH) || (state_reg == S_EXEC) || (state_reg == S_LWAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      cnt_reg   <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      cnt_reg   <= cnt_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    cnt_next   = cnt_reg;
    wait_next  = wait_reg;

    if (active && (cnt_reg != 16'hFFFF)) begin
      cnt_next = cnt_reg + 16'd1;
    end

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_next    = START_PC;
          cnt_next   = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_next    = imem_data;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_halt) begin
          state_next = S_DONE;
        end else begin
          // Unconditional jump outranks the conditional branch.
          if (branch_flag || (cond_branch && branch_taken)) begin
            pc_next = branch_target;
          end else begin
            pc_next = pc_reg + PC_W'(1);
          end
          if (mem_to_reg && HAS_WAIT) begin
            wait_next  = WAIT_INIT - 4'd1;
            state_next = S_LWAIT;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_LWAIT: begin
        if (wait_reg == 4'd0) begin
          state_next = S_FETCH;
        end else begin
          wait_next = wait_reg - 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign imem_req    = (state_reg == S_FETCH);
  assign imem_addr   = pc_reg;
  assign ir          = ir_reg;
  assign exec_en     = (state_reg == S_EXEC) && !is_halt;
  assign pc          = pc_reg;
  assign busy        = active;
  assign done        = (state_reg == S_DONE);
  assign cycle_count = cnt_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: the stimulus side plays memory and decoder and queues the
// expected fetch/exec events from an instruction-level model; a monitor checks them.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam int PC_W = 10;
  localparam int LW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            imem_valid = 1'b0;
  logic [8:0]      imem_data = '0;
  logic            branch_flag = 1'b0, cond_branch = 1'b0, branch_taken = 1'b0, mem_to_reg = 1'b0;
  logic [PC_W-1:0] branch_target = '0;
  logic            imem_req, exec_en, busy, done;
  logic [PC_W-1:0] imem_addr, pc;
  logic [8:0]      ir;
  logic [15:0]     cycle_count;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(PC_W), .START_PC(10'd0), .LOAD_WAIT(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .ir(ir), .branch_flag(branch_flag), .cond_branch(cond_branch), .branch_taken(branch_taken),
    .mem_to_reg(mem_to_reg), .branch_target(branch_target), .exec_en(exec_en), .pc(pc),
    .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  typedef struct {
    int lat; logic [8:0] ir; bit bf; bit cb; bit bt; bit ml; logic [PC_W-1:0] tgt; bit pstart; bit abort;
  } instr_t;
  typedef struct { logic [PC_W-1:0] addr; int gap; } fexp_t;
  typedef struct { logic [PC_W-1:0] pc; logic [8:0] ir; logic [15:0] cc; bit halt; } xexp_t;

  instr_t prog[$];
  fexp_t  addr_q[$];
  xexp_t  exec_q[$];
  int checks = 0;
  int passes = 0;
  int model_pc, model_cc, model_gap;

  localparam logic [8:0] HALT = 9'h01E;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic logic [15:0] sat(int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic bit is_halt(logic [8:0] i);
    return i[4:0] == 5'b11110;
  endfunction

  task automatic finish_bench();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  task automatic add_i(int lat, logic [8:0] i, bit bf, bit cb, bit bt, bit ml, int tgt, bit ps, bit ab);
    instr_t it;
    it.lat = lat; it.ir = i; it.bf = bf; it.cb = cb; it.bt = bt; it.ml = ml;
    it.tgt = PC_W'(tgt); it.pstart = ps; it.abort = ab;
    prog.push_back(it);
  endtask

  // Expected events for an instruction about to be fetched at model_pc.
  task automatic push_expect(instr_t it);
    fexp_t f; xexp_t x; bit h;
    h = is_halt(it.ir);
    f.addr = PC_W'(model_pc); f.gap = model_gap;
    x.pc = PC_W'(model_pc); x.ir = it.ir; x.halt = h;
    x.cc = sat(model_cc + it.lat + (h ? 2 : 1));
    addr_q.push_back(f);
    exec_q.push_back(x);
  endtask

  task automatic advance(instr_t it);
    if (is_halt(it.ir)) begin
      model_cc += it.lat + 2;
    end else begin
      model_cc  += it.lat + 2 + (it.ml ? LW : 0);
      model_gap  = it.ml ? LW : 0;
      if (it.bf || (it.cb && it.bt)) model_pc = int'(it.tgt);
      else model_pc = (model_pc + 1) % (1 << PC_W);
    end
  endtask

  task automatic scramble();
    branch_flag = 1'($urandom); cond_branch = 1'($urandom);
    branch_taken = 1'($urandom); mem_to_reg = 1'($urandom);
    branch_target = PC_W'($urandom);
  endtask

  task automatic do_abort();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", imem_req, 0);
    chk("rst_mid_pc", pc, 0);
    chk("rst_mid_ir", ir, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cc", cycle_count, 0);
    addr_q.delete();
    exec_q.delete();
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);
  endtask

  // Entered and left on a negedge; the final halt leaves the DUT in DONE.
  task automatic run_prog();
    instr_t it; int n;
    model_pc = 0; model_cc = 0; model_gap = 0;
    push_expect(prog[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (prog[k]) begin
      it = prog[k];
      n = 0;
      while (!imem_req && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!imem_req) begin
        checks++;
        $display("FAIL fetch_timeout: imem_req=%0b after %0d cycles, expected 1", imem_req, n);
        finish_bench();
      end
      for (int i = 0; i < it.lat; i++) begin
        imem_data = 9'($urandom);
        start = it.pstart && (i == 10);
        if (it.abort && i == 2) begin
          do_abort();
          return;
        end
        @(negedge clk);
      end
      start = 1'b0;
      imem_valid = 1'b1;
      imem_data = it.ir;
      @(negedge clk);
      imem_valid = 1'b0;
      imem_data = 9'($urandom);
      branch_flag = it.bf; cond_branch = it.cb; branch_taken = it.bt;
      mem_to_reg = it.ml; branch_target = it.tgt;
      advance(it);
      if (k + 1 < prog.size()) push_expect(prog[k+1]);
      @(negedge clk);
      scramble();
    end
  endtask

  initial begin : monitor
    logic prev_req, prev_done;
    int gap;
    fexp_t f; xexp_t x;
    prev_req = 1'b0; prev_done = 1'b0; gap = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_req = 1'b0; prev_done = 1'b0; gap = 0;
      end else begin
        if (imem_req && !prev_req) begin
          if (addr_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_fetch: addr=%0d with no fetch expected", imem_addr);
          end else begin
            f = addr_q.pop_front();
            chk("fetch_addr", imem_addr, f.addr);
            chk("lwait_cycles", gap, f.gap);
          end
          gap = 0;
        end
        if (exec_en || (done && !prev_done)) begin
          if (exec_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_exec: exec_en=%0b done=%0b with nothing expected", exec_en, done);
          end else begin
            x = exec_q.pop_front();
            $display("%s pc=%0d ir=%03h cycle_count=%0d", done ? "halt" : "exec", pc, ir, cycle_count);
            chk("exec_is_halt", done, x.halt);
            chk("exec_pc", pc, x.pc);
            chk("exec_ir", ir, x.ir);
            chk("exec_cycles", cycle_count, x.cc);
          end
        end
        if (busy && !imem_req && !exec_en) gap++;
        else if (!busy) gap = 0;
        prev_req = imem_req;
        prev_done = done;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [8:0] r;
    #1;
    chk("reset_req", imem_req, 0);
    chk("reset_exec", exec_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pc", pc, 0);
    chk("reset_ir", ir, 0);
    chk("reset_cc", cycle_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Sequential add, add, halt; then restart from DONE.
    repeat (2) begin
      prog.delete();
      add_i(0, 9'h002, 0, 0, 0, 0, 0, 0, 0);
      add_i(0, 9'h004, 0, 0, 0, 0, 0, 0, 0);
      add_i(0, HALT,   0, 0, 0, 0, 0, 0, 0);
      run_prog();
    end

    // Jump priority over a not-taken conditional branch.
    prog.delete();
    add_i(0, 9'h012, 1, 0, 0, 0, 5,  0, 0);
    add_i(0, 9'h013, 1, 1, 0, 0, 40, 0, 0);
    add_i(1, 9'h012, 1, 0, 0, 0, 5,  0, 0);
    add_i(0, 9'h013, 0, 1, 0, 0, 40, 0, 0);
    add_i(0, 9'h013, 0, 1, 1, 0, 9,  0, 0);
    add_i(0, 9'h1FE, 0, 0, 0, 0, 0,  0, 0);
    run_prog();

    // Load stall at pc=3.
    prog.delete();
    add_i(0, 9'h012, 1, 0, 0, 0, 3, 0, 0);
    add_i(0, 9'h0A4, 0, 0, 0, 1, 0, 0, 0);
    add_i(0, 9'h0A4, 0, 0, 0, 1, 0, 0, 0);
    add_i(0, HALT,   0, 0, 0, 0, 0, 0, 0);
    run_prog();

    // Slow memory and PC wrap at 1023.
    prog.delete();
    add_i(0, 9'h012, 1, 0, 0, 0, 1023, 0, 0);
    add_i(3, 9'h033, 0, 0, 0, 0, 0,    0, 0);
    add_i(0, HALT,   0, 0, 0, 0, 0,    0, 0);
    run_prog();

    // Randomized programs.
    repeat (3) begin
      prog.delete();
      for (int i = 0; i < 40; i++) begin
        r = 9'($urandom);
        if (r[4:0] == 5'b11110) r[0] = 1'b1;
        add_i($urandom_range(0, 3), r, ($urandom % 6) == 0, ($urandom % 3) == 0,
              1'($urandom), ($urandom % 4) == 0, $urandom_range(0, 1023), 0, 0);
      end
      add_i($urandom_range(0, 3), HALT, 0, 0, 0, 0, 0, 0, 0);
      run_prog();
    end

    // Reset while fetching at a nonzero pc, then a fresh run.
    prog.delete();
    add_i(0, 9'h0C5, 1, 0, 0, 0, 77, 0, 0);
    add_i(5, 9'h002, 0, 0, 0, 0, 0,  0, 1);
    run_prog();
    prog.delete();
    add_i(1, 9'h002, 0, 0, 0, 0, 0, 0, 0);
    add_i(0, HALT,   0, 0, 0, 0, 0, 0, 0);
    run_prog();

    // Saturating cycle counter with start pulsed during the stalled fetch.
    prog.delete();
    add_i(0, 9'h012, 1, 0, 0, 0, 300, 0, 0);
    add_i(70000, HALT, 0, 0, 0, 0, 0, 1, 0);
    run_prog();

    repeat (3) @(negedge clk);
    chk("final_cc_held", cycle_count, 16'hFFFF);
    chk("final_done", done, 1);
    chk("addr_q_drained", addr_q.size(), 0);
    chk("exec_q_drained", exec_q.size(), 0);
    finish_bench();
  end

endmodule
